// File: rtl/hawk_zspg_md_xfer.sv
`default_nettype none
// ============================================================================
// Module   : hawk_zspg_md_xfer
// Brief    : ZsPage metadata transfer engine. Serialises a metadata record
//            into 512-bit beats and writes it with one AXI4 burst, or fetches
//            a record with one AXI4 burst read and deserialises it.
// Revision : 1.0 - initial release
// ============================================================================
module hawk_zspg_md_xfer #(
  parameter  int NUM_PAGES   = 5,
  parameter  int NUM_WAYS    = 3,
  parameter  int PTR_W       = 48,
  parameter  int ADDR_W      = 64,
  parameter  bit BYTESWAP_EN = 1'b1,
  localparam int MD_BITS     = 8 + NUM_WAYS + NUM_PAGES + PTR_W * (NUM_WAYS + NUM_PAGES),
  localparam int NBEATS      = (MD_BITS + 511) / 512,
  localparam int LAST_BYTES  = (MD_BITS + 7) / 8 - 64 * (NBEATS - 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_write_i,
  input  logic [ADDR_W-1:0]  req_addr_i,
  input  logic [MD_BITS-1:0] req_md_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [MD_BITS-1:0] rsp_md_o,
  output logic               rsp_err_o,
  output logic               m_awvalid_o,
  input  logic               m_awready_i,
  output logic [ADDR_W-1:0]  m_awaddr_o,
  output logic [7:0]         m_awlen_o,
  output logic               m_wvalid_o,
  input  logic               m_wready_i,
  output logic [511:0]       m_wdata_o,
  output logic [63:0]        m_wstrb_o,
  output logic               m_wlast_o,
  input  logic               m_bvalid_i,
  output logic               m_bready_o,
  input  logic [1:0]         m_bresp_i,
  output logic               m_arvalid_o,
  input  logic               m_arready_i,
  output logic [ADDR_W-1:0]  m_araddr_o,
  output logic [7:0]         m_arlen_o,
  input  logic               m_rvalid_i,
  output logic               m_rready_o,
  input  logic [511:0]       m_rdata_i,
  input  logic [1:0]         m_rresp_i,
  input  logic               m_rlast_i
);

  localparam int                c_beat_w    = $clog2(NBEATS + 1);
  localparam int                c_pad_bits  = NBEATS * 512;
  localparam logic [63:0]       c_last_strb = {64{1'b1}} >> (64 - LAST_BYTES);
  localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(NBEATS - 1);
  localparam logic [c_beat_w-1:0] c_nbeats    = c_beat_w'(NBEATS);
  localparam logic [7:0]        c_axlen     = 8'(NBEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR_AW = 3'd1,
    S_WR_W  = 3'd2,
    S_WR_B  = 3'd3,
    S_RD_AR = 3'd4,
    S_RD_R  = 3'd5,
    S_RSP   = 3'd6
  } state_t;

  state_t                     r_state;
  logic [ADDR_W-1:0]          r_addr;
  logic                       r_write;
  logic [NBEATS-1:0][511:0]   r_md;
  logic [c_beat_w-1:0]        r_beat;
  logic                       r_err;
  logic                       r_req_ready;
  logic                       r_awvalid;
  logic                       r_wvalid;
  logic                       r_bready;
  logic                       r_arvalid;
  logic                       r_rready;
  logic                       r_rsp_valid;

  logic [511:0]               w_wdata_raw;
  logic [511:0]               w_wdata_sw;
  logic [63:0]                w_wstrb_raw;
  logic [63:0]                w_wstrb_sw;
  logic [511:0]               w_rdata_sw;
  logic [c_pad_bits-1:0]      w_md_flat;
  logic                       w_unused;

  // Pick the beat currently on the W channel; only the final beat is partial.
  always_comb begin
    w_wdata_raw = '0;
    for (int k = 0; k < NBEATS; k++) begin
      if (r_beat == c_beat_w'(k)) w_wdata_raw = r_md[k];
    end
    w_wstrb_raw = (r_beat == c_last_beat) ? c_last_strb : {64{1'b1}};
  end

  // Byte order within each 8-byte group is reversed on both data paths; the
  // same permutation is its own inverse, so reads reuse it to unswap.
  generate
    if (BYTESWAP_EN) begin : g_swap
      for (genvar gi = 0; gi < 8; gi++) begin : g_grp
        for (genvar bi = 0; bi < 8; bi++) begin : g_byte
          assign w_wdata_sw[gi*64 + bi*8 +: 8] = w_wdata_raw[gi*64 + (7-bi)*8 +: 8];
          assign w_rdata_sw[gi*64 + bi*8 +: 8] = m_rdata_i[gi*64 + (7-bi)*8 +: 8];
          assign w_wstrb_sw[gi*8 + bi]         = w_wstrb_raw[gi*8 + 7 - bi];
        end
      end
    end else begin : g_noswap
      assign w_wdata_sw = w_wdata_raw;
      assign w_rdata_sw = m_rdata_i;
      assign w_wstrb_sw = w_wstrb_raw;
    end
  endgenerate

  // Transfer sequencer: request latch, AXI address/data/response phases and
  // completion hand-off, with all handshake outputs registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_md        <= '0;
      r_beat      <= '0;
      r_err       <= 1'b0;
      r_req_ready <= 1'b1;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i && r_req_ready) begin
            r_addr      <= {req_addr_i[ADDR_W-1:6], 6'd0};
            r_write     <= req_write_i;
            r_md        <= c_pad_bits'(req_md_i);
            r_err       <= 1'b0;
            r_beat      <= '0;
            r_req_ready <= 1'b0;
            if (req_write_i) begin
              r_awvalid <= 1'b1;
              r_state   <= S_WR_AW;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_AR;
            end
          end
        end
        S_WR_AW: begin
          if (m_awready_i) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_beat    <= '0;
            r_state   <= S_WR_W;
          end
        end
        S_WR_W: begin
          if (m_wready_i) begin
            if (r_beat == c_last_beat) begin
              r_wvalid <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= S_WR_B;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        S_WR_B: begin
          if (m_bvalid_i) begin
            if (m_bresp_i != 2'b00) r_err <= 1'b1;
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end
        end
        S_RD_AR: begin
          if (m_arready_i) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_beat    <= '0;
            r_state   <= S_RD_R;
          end
        end
        S_RD_R: begin
          if (m_rvalid_i) begin
            // Beats past the record length match no slot and are dropped.
            for (int k = 0; k < NBEATS; k++) begin
              if (r_beat == c_beat_w'(k)) r_md[k] <= w_rdata_sw;
            end
            if (m_rresp_i != 2'b00) r_err <= 1'b1;
            if (m_rlast_i) begin
              // rlast anywhere but the final record beat is a length error.
              if (r_beat != c_last_beat) r_err <= 1'b1;
              r_rready    <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RSP;
            end else begin
              // Final record beat arrived without rlast: drain the overrun.
              if (r_beat == c_last_beat) r_err <= 1'b1;
              if (r_beat != c_nbeats) r_beat <= r_beat + 1'b1;
            end
          end
        end
        S_RSP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_md_flat   = r_md;
  assign w_unused    = &{1'b0, req_addr_i[5:0], w_md_flat};

  assign req_ready_o = r_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_err;
  assign rsp_md_o    = r_write ? '0 : w_md_flat[MD_BITS-1:0];

  assign m_awvalid_o = r_awvalid;
  assign m_awaddr_o  = r_awvalid ? r_addr : '0;
  assign m_awlen_o   = r_awvalid ? c_axlen : 8'd0;
  assign m_wvalid_o  = r_wvalid;
  assign m_wdata_o   = r_wvalid ? w_wdata_sw : '0;
  assign m_wstrb_o   = r_wvalid ? w_wstrb_sw : '0;
  assign m_wlast_o   = r_wvalid && (r_beat == c_last_beat);
  assign m_bready_o  = r_bready;
  assign m_arvalid_o = r_arvalid;
  assign m_araddr_o  = r_arvalid ? r_addr : '0;
  assign m_arlen_o   = r_arvalid ? c_axlen : 8'd0;
  assign m_rready_o  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_hawk_zspg_md_xfer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hawk_zspg_md_xfer
// Brief    : Self-checking bench. Instance A uses default parameters
//            (single beat, byteswap on); instance B uses 12 pages with
//            byteswap off (two-beat record). A small AXI slave lives in each
//            scenario task; expectations come from a bit-level record model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hawk_zspg_md_xfer;

  localparam int MDA = 400;
  localparam int MDB = 743;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- instance A signals ----------------
  logic a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [63:0] a_req_addr;
  logic [MDA-1:0] a_req_md, a_rsp_md;
  logic a_awvalid, a_awready, a_wvalid, a_wready, a_wlast, a_bvalid, a_bready;
  logic a_arvalid, a_arready, a_rvalid, a_rready, a_rlast;
  logic [63:0] a_awaddr, a_araddr, a_wstrb;
  logic [7:0] a_awlen, a_arlen;
  logic [511:0] a_wdata, a_rdata;
  logic [1:0] a_bresp, a_rresp;

  // ---------------- instance B signals ----------------
  logic b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [63:0] b_req_addr;
  logic [MDB-1:0] b_req_md, b_rsp_md;
  logic b_awvalid, b_awready, b_wvalid, b_wready, b_wlast, b_bvalid, b_bready;
  logic b_arvalid, b_arready, b_rvalid, b_rready, b_rlast;
  logic [63:0] b_awaddr, b_araddr, b_wstrb;
  logic [7:0] b_awlen, b_arlen;
  logic [511:0] b_wdata, b_rdata;
  logic [1:0] b_bresp, b_rresp;

  hawk_zspg_md_xfer u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_write_i(a_req_write),
    .req_addr_i(a_req_addr), .req_md_i(a_req_md),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_md_o(a_rsp_md), .rsp_err_o(a_rsp_err),
    .m_awvalid_o(a_awvalid), .m_awready_i(a_awready), .m_awaddr_o(a_awaddr), .m_awlen_o(a_awlen),
    .m_wvalid_o(a_wvalid), .m_wready_i(a_wready), .m_wdata_o(a_wdata), .m_wstrb_o(a_wstrb), .m_wlast_o(a_wlast),
    .m_bvalid_i(a_bvalid), .m_bready_o(a_bready), .m_bresp_i(a_bresp),
    .m_arvalid_o(a_arvalid), .m_arready_i(a_arready), .m_araddr_o(a_araddr), .m_arlen_o(a_arlen),
    .m_rvalid_i(a_rvalid), .m_rready_o(a_rready), .m_rdata_i(a_rdata), .m_rresp_i(a_rresp), .m_rlast_i(a_rlast)
  );

  hawk_zspg_md_xfer #(.NUM_PAGES(12), .BYTESWAP_EN(1'b0)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_write_i(b_req_write),
    .req_addr_i(b_req_addr), .req_md_i(b_req_md),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_md_o(b_rsp_md), .rsp_err_o(b_rsp_err),
    .m_awvalid_o(b_awvalid), .m_awready_i(b_awready), .m_awaddr_o(b_awaddr), .m_awlen_o(b_awlen),
    .m_wvalid_o(b_wvalid), .m_wready_i(b_wready), .m_wdata_o(b_wdata), .m_wstrb_o(b_wstrb), .m_wlast_o(b_wlast),
    .m_bvalid_i(b_bvalid), .m_bready_o(b_bready), .m_bresp_i(b_bresp),
    .m_arvalid_o(b_arvalid), .m_arready_i(b_arready), .m_araddr_o(b_araddr), .m_arlen_o(b_arlen),
    .m_rvalid_i(b_rvalid), .m_rready_o(b_rready), .m_rdata_i(b_rdata), .m_rresp_i(b_rresp), .m_rlast_i(b_rlast)
  );

  // ---------------- reference model ----------------
  // Build a record field by field, LSB first, with random pointers.
  function automatic logic [1023:0] m_rec(input int nw, input int np, input logic [7:0] size,
                                          input logic [7:0] wv, input logic [31:0] pv);
    logic [1023:0] r;
    logic [47:0]   p;
    int            pos;
    r = '0;
    pos = 0;
    for (int i = 0; i < 8; i++)  begin r[pos] = size[i]; pos++; end
    for (int i = 0; i < nw; i++) begin r[pos] = wv[i];   pos++; end
    for (int i = 0; i < np; i++) begin r[pos] = pv[i];   pos++; end
    for (int i = 0; i < nw + np; i++) begin
      p = 48'({$urandom(), $urandom()});
      for (int b = 0; b < 48; b++) begin r[pos] = p[b]; pos++; end
    end
    return r;
  endfunction

  // Byte i of the beat travels to byte i^7 (reversal inside each 8-byte group).
  function automatic logic [511:0] m_swap(input logic [511:0] d);
    logic [511:0] o;
    for (int i = 0; i < 64; i++) o[i*8 +: 8] = d[(i ^ 7)*8 +: 8];
    return o;
  endfunction

  // Byte j of beat k is enabled when it lies inside the record's byte length.
  function automatic logic [63:0] m_strb(input int beat, input int md_bits, input bit swap);
    logic [63:0] s;
    logic [63:0] o;
    int nbytes;
    nbytes = (md_bits + 7) / 8;
    for (int j = 0; j < 64; j++) s[j] = (beat * 64 + j < nbytes);
    for (int j = 0; j < 64; j++) o[j] = swap ? s[j ^ 7] : s[j];
    return o;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    n_tests++; if ({a_req_ready, a_rsp_valid, a_awvalid, a_wvalid, a_wlast, a_bready, a_arvalid, a_rready, a_rsp_err} !== 9'b1_0000_0000) begin
      n_fail++; $display("FAIL reset_ctrl_a: got %b expected 100000000", {a_req_ready, a_rsp_valid, a_awvalid, a_wvalid, a_wlast, a_bready, a_arvalid, a_rready, a_rsp_err}); end
    n_tests++; if ({a_awaddr, a_araddr, a_wstrb, a_awlen, a_arlen} !== '0 || a_wdata !== '0 || a_rsp_md !== '0) begin
      n_fail++; $display("FAIL reset_bus_a: awaddr=%h wstrb=%h awlen=%h expected all zero", a_awaddr, a_wstrb, a_awlen); end
    n_tests++; if ({b_req_ready, b_rsp_valid, b_awvalid, b_wvalid, b_wlast, b_bready, b_arvalid, b_rready, b_rsp_err} !== 9'b1_0000_0000) begin
      n_fail++; $display("FAIL reset_ctrl_b: got %b expected 100000000", {b_req_ready, b_rsp_valid, b_awvalid, b_wvalid, b_wlast, b_bready, b_arvalid, b_rready, b_rsp_err}); end
  endtask

  task automatic test_write_a(input logic [MDA-1:0] md, input logic [63:0] addr, input bit plan_vec);
    int lat, aw_n, w_n;
    logic [63:0] g_awaddr, g_wstrb;
    logic [7:0] g_awlen;
    logic [511:0] g_wdata;
    logic g_wlast;
    lat = -1; aw_n = 0; w_n = 0;
    g_awaddr = '0; g_wstrb = '0; g_awlen = '0; g_wdata = '0; g_wlast = 1'b0;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = addr; a_req_md = md;
    a_awready = 1'b1; a_wready = 1'b1; a_rsp_ready = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      a_req_valid = 1'b0; a_bvalid = 1'b0;
      if (a_awvalid) begin aw_n++; g_awaddr = a_awaddr; g_awlen = a_awlen; end
      if (a_wvalid)  begin w_n++; g_wdata = a_wdata; g_wstrb = a_wstrb; g_wlast = a_wlast; end
      if (a_bready)  begin a_bvalid = 1'b1; a_bresp = 2'b00; end
      if (a_rsp_valid) begin lat = cyc; break; end
    end
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL wr_a_latency: got %0d expected 4", lat); end
    n_tests++; if (aw_n !== 1 || g_awaddr !== {addr[63:6], 6'd0} || g_awlen !== 8'd0) begin
      n_fail++; $display("FAIL wr_a_aw: n=%0d addr=%h len=%0d expected n=1 addr=%h len=0", aw_n, g_awaddr, g_awlen, {addr[63:6], 6'd0}); end
    n_tests++; if (w_n !== 1 || g_wlast !== 1'b1 || g_wstrb !== m_strb(0, MDA, 1'b1)) begin
      n_fail++; $display("FAIL wr_a_wctl: n=%0d last=%b strb=%h expected n=1 last=1 strb=%h", w_n, g_wlast, g_wstrb, m_strb(0, MDA, 1'b1)); end
    n_tests++; if (g_wdata !== m_swap(512'(md))) begin
      n_fail++; $display("FAIL wr_a_wdata: got %h expected %h", g_wdata, m_swap(512'(md))); end
    if (plan_vec) begin
      n_tests++; if (g_wstrb !== 64'h00C0_FFFF_FFFF_FFFF || g_awaddr !== 64'h0000_00FF_F640_0000) begin
        n_fail++; $display("FAIL wr_a_plan: strb=%h addr=%h expected 00c0ffffffffffff 000000fff6400000", g_wstrb, g_awaddr); end
    end
    n_tests++; if (a_rsp_err !== 1'b0 || a_rsp_md !== '0) begin
      n_fail++; $display("FAIL wr_a_rsp: err=%b md_nonzero=%b expected err=0 md=0", a_rsp_err, |a_rsp_md); end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    n_tests++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL wr_a_done: rsp_valid=%b req_ready=%b expected 0 1", a_rsp_valid, a_req_ready); end
  endtask

  task automatic test_read_a(input logic [MDA-1:0] md, input int hold);
    int lat;
    bit sent;
    lat = -1; sent = 1'b0;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = {$urandom(), $urandom()};
    a_req_md = ~md; a_arready = 1'b1; a_rsp_ready = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      a_req_valid = 1'b0; a_rvalid = 1'b0; a_rlast = 1'b0;
      if (a_rready && !sent) begin
        a_rvalid = 1'b1; a_rdata = m_swap(512'(md)); a_rresp = 2'b00; a_rlast = 1'b1; sent = 1'b1;
      end
      if (a_rsp_valid) begin lat = cyc; break; end
    end
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL rd_a_latency: got %0d expected 3", lat); end
    n_tests++; if (a_rsp_md !== md || a_rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL rd_a_data: err=%b md=%h expected err=0 md=%h", a_rsp_err, a_rsp_md, md); end
    // Completion backpressure with a competing request on the input.
    for (int h = 0; h < hold; h++) begin
      a_req_valid = 1'b1; a_req_write = 1'b1;
      @(negedge clk);
      n_tests++; if (a_rsp_valid !== 1'b1 || a_rsp_md !== md || a_req_ready !== 1'b0 || a_awvalid !== 1'b0) begin
        n_fail++; $display("FAIL rd_a_hold%0d: rsp_valid=%b req_ready=%b awvalid=%b md_ok=%b expected 1 0 0 1", h, a_rsp_valid, a_req_ready, a_awvalid, a_rsp_md === md); end
    end
    a_req_valid = 1'b0; a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    n_tests++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_awvalid !== 1'b0) begin
      n_fail++; $display("FAIL rd_a_done: rsp_valid=%b req_ready=%b awvalid=%b expected 0 1 0", a_rsp_valid, a_req_ready, a_awvalid); end
  endtask

  task automatic test_write_b(input logic [MDB-1:0] md);
    logic [1023:0] pad;
    logic [511:0] g_data [2];
    logic [63:0] g_strb [2];
    logic g_last [2];
    logic [511:0] snap;
    logic [7:0] g_awlen;
    int w_n, stall, unstable;
    bit got_rsp;
    pad = 1024'(md); w_n = 0; stall = 0; unstable = 0; got_rsp = 1'b0; g_awlen = 8'hFF; snap = '0;
    for (int i = 0; i < 2; i++) begin g_data[i] = '0; g_strb[i] = '0; g_last[i] = 1'b0; end
    @(negedge clk);
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = {$urandom(), $urandom()}; b_req_md = md;
    b_awready = 1'b1; b_wready = 1'b0; b_rsp_ready = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      b_req_valid = 1'b0; b_bvalid = 1'b0;
      if (b_awvalid) g_awlen = b_awlen;
      if (b_wvalid) begin
        if (w_n == 0 && stall < 3) begin
          if (stall == 0) snap = b_wdata; else if (b_wdata !== snap) unstable++;
          stall++; b_wready = 1'b0;
        end else if (w_n < 2) begin
          if (w_n == 0 && b_wdata !== snap) unstable++;
          b_wready = 1'b1; g_data[w_n] = b_wdata; g_strb[w_n] = b_wstrb; g_last[w_n] = b_wlast; w_n++;
        end
      end
      if (b_bready) begin b_bvalid = 1'b1; b_bresp = 2'b00; end
      if (b_rsp_valid) begin got_rsp = 1'b1; break; end
    end
    b_wready = 1'b0;
    n_tests++; if (!got_rsp || g_awlen !== 8'd1 || w_n !== 2) begin
      n_fail++; $display("FAIL wr_b_burst: rsp=%b awlen=%0d beats=%0d expected 1 1 2", got_rsp, g_awlen, w_n); end
    n_tests++; if (unstable !== 0) begin n_fail++; $display("FAIL wr_b_stall_stable: %0d changes expected 0", unstable); end
    n_tests++; if (g_data[0] !== pad[511:0] || g_data[1] !== pad[1023:512]) begin
      n_fail++; $display("FAIL wr_b_wdata: beat0=%h beat1=%h expected %h %h", g_data[0], g_data[1], pad[511:0], pad[1023:512]); end
    n_tests++; if (g_strb[0] !== m_strb(0, MDB, 1'b0) || g_strb[1] !== m_strb(1, MDB, 1'b0) || g_strb[1] !== 64'h0000_0000_1FFF_FFFF) begin
      n_fail++; $display("FAIL wr_b_wstrb: %h %h expected %h %h", g_strb[0], g_strb[1], m_strb(0, MDB, 1'b0), m_strb(1, MDB, 1'b0)); end
    n_tests++; if (g_last[0] !== 1'b0 || g_last[1] !== 1'b1 || b_rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL wr_b_last_err: wlast=%b%b err=%b expected 01 0", g_last[0], g_last[1], b_rsp_err); end
    b_rsp_ready = 1'b1;
    @(negedge clk);
    b_rsp_ready = 1'b0;
  endtask

  // nret beats offered, rlast on beat rlast_at, SLVERR on beat bad_at (-1 none).
  task automatic test_read_b(input string name, input int nret, input int rlast_at, input int bad_at);
    logic [511:0] beats [4];
    logic [1023:0] exp_pad;
    logic [MDB-1:0] req_md, exp_md;
    logic [7:0] g_arlen;
    int sent, lat, exp_acc;
    bit exp_err;
    sent = 0; lat = -1; g_arlen = 8'hFF;
    for (int i = 0; i < 4; i++) beats[i] = {16{$urandom()}};
    req_md = MDB'({24{$urandom()}});
    @(negedge clk);
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = {$urandom(), $urandom()}; b_req_md = req_md;
    b_arready = 1'b1; b_rsp_ready = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      b_req_valid = 1'b0; b_rvalid = 1'b0; b_rlast = 1'b0;
      if (b_arvalid) g_arlen = b_arlen;
      if (b_rready && sent < nret) begin
        b_rvalid = 1'b1; b_rdata = beats[sent]; b_rresp = (sent == bad_at) ? 2'b10 : 2'b00;
        b_rlast = (sent == rlast_at); sent++;
      end
      if (b_rsp_valid) begin lat = cyc; break; end
    end
    exp_acc = (rlast_at + 1 < nret) ? rlast_at + 1 : nret;
    exp_pad = 1024'(req_md);
    for (int k = 0; k < exp_acc && k < 2; k++) exp_pad[k*512 +: 512] = beats[k];
    exp_md = exp_pad[MDB-1:0];
    exp_err = (bad_at >= 0 && bad_at < exp_acc) || (rlast_at != 1);
    n_tests++; if (lat < 0 || sent !== exp_acc || g_arlen !== 8'd1) begin
      n_fail++; $display("FAIL %s_beats: rsp_cyc=%0d accepted=%0d arlen=%0d expected accepted=%0d arlen=1", name, lat, sent, g_arlen, exp_acc); end
    n_tests++; if (b_rsp_err !== exp_err || b_rsp_md !== exp_md) begin
      n_fail++; $display("FAIL %s_rsp: err=%b md_ok=%b expected err=%b", name, b_rsp_err, b_rsp_md === exp_md, exp_err); end
    if (!exp_err && nret == 2) begin
      n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL %s_latency: got %0d expected 4", name, lat); end
    end
    b_rsp_ready = 1'b1;
    @(negedge clk);
    b_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    bit in_w;
    in_w = 1'b0;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 64'h1000; a_req_md = '1;
    a_awready = 1'b1; a_wready = 1'b0;
    for (int cyc = 0; cyc < 20 && !in_w; cyc++) begin
      @(negedge clk);
      a_req_valid = 1'b0;
      in_w = a_wvalid;
    end
    n_tests++; if (!in_w) begin n_fail++; $display("FAIL rst_mid_reach: wvalid never seen, expected 1"); end
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if ({a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready, a_rsp_valid, a_req_ready} !== 7'b000_0001) begin
      n_fail++; $display("FAIL rst_mid_state: got %b expected 0000001", {a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready, a_rsp_valid, a_req_ready}); end
    rst = 1'b0; a_wready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [1023:0] r;
    for (int i = 0; i < 2; i++) begin
      r = m_rec(3, 5, 8'($urandom()), 8'($urandom()), $urandom());
      test_write_a(r[MDA-1:0], {$urandom(), $urandom()}, 1'b0);
      r = m_rec(3, 5, 8'($urandom()), 8'($urandom()), $urandom());
      test_read_a(r[MDA-1:0], 0);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [1023:0] r;
    rst = 1'b1;
    a_req_valid = 0; a_req_write = 0; a_req_addr = '0; a_req_md = '0; a_rsp_ready = 0;
    a_awready = 0; a_wready = 0; a_bvalid = 0; a_bresp = 0; a_arready = 0;
    a_rvalid = 0; a_rdata = '0; a_rresp = 0; a_rlast = 0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = '0; b_req_md = '0; b_rsp_ready = 0;
    b_awready = 0; b_wready = 0; b_bvalid = 0; b_bresp = 0; b_arready = 0;
    b_rvalid = 0; b_rdata = '0; b_rresp = 0; b_rlast = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    test_reset();
    r = m_rec(3, 5, 8'h05, 8'b001, 32'b00011);
    test_write_a(r[MDA-1:0], 64'h0000_00FF_F640_0013, 1'b1);
    for (int i = 0; i < 3; i++) begin
      r = m_rec(3, 5, 8'($urandom()), 8'($urandom()), $urandom());
      test_write_a(r[MDA-1:0], {$urandom(), $urandom()}, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      r = m_rec(3, 5, 8'($urandom()), 8'($urandom()), $urandom());
      test_read_a(r[MDA-1:0], 0);
    end
    r = m_rec(3, 5, 8'($urandom()), 8'($urandom()), $urandom());
    test_read_a(r[MDA-1:0], 5);
    r = m_rec(3, 12, 8'($urandom()), 8'($urandom()), $urandom());
    test_write_b(r[MDB-1:0]);
    test_read_b("rd_b_clean", 2, 1, -1);
    test_read_b("rd_b_slverr", 2, 1, 0);
    test_read_b("rd_b_early", 2, 0, -1);
    test_read_b("rd_b_long", 3, 2, -1);
    test_reset_midflight();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hawk_zspg_md_xfer.md
Name: hawk_zspg_md_xfer

Overview:
- Parametrised ZsPage metadata transfer engine for the HACD/Hawk compression path.
- Write mode: serialises one ZsPage metadata record (size, way/page valids, way pointers, page pointers) into 512-bit cacheline beats and issues an AXI4 burst write.
- Read mode: fetches and deserialises a record with an AXI4 burst read.
- Generalises the fixed 5-page/3-way, single-cacheline record to any page/way count, multi-beat records and optional per-8-byte byteswap. Sits between the zspage manager and the Hawk AXI write/read masters.

Parameters:
- NUM_PAGES, 5, page pointer slots per ZsPage (1..32)
- NUM_WAYS, 3, way pointer slots per ZsPage (1..8)
- PTR_W, 48, width of each way/page pointer in bits
- ADDR_W, 64, AXI address width
- BYTESWAP_EN, 1, 1 = byte-reverse within every 8-byte group of wdata/wstrb/rdata
- Derived MD_BITS = 8+NUM_WAYS+NUM_PAGES+PTR_W*(NUM_WAYS+NUM_PAGES) (400 at defaults)
- Derived NBEATS = ceil(MD_BITS/512)
- Derived LAST_BYTES = ceil(MD_BITS/8) - 64*(NBEATS-1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_write_i  in  1  1 = write record, 0 = read record
- req_addr_i  in  ADDR_W  record base address; bits [5:0] ignored (forced 0)
- req_md_i  in  MD_BITS  record to write. Packing LSB-first: size[7:0], way_vld, pg_vld, way0..wayN-1, page0..pageN-1
- rsp_valid_o  out  1  completion valid
- rsp_ready_i  in  1  completion accepted
- rsp_md_o  out  MD_BITS  record read (undefined for writes; held 0)
- rsp_err_o  out  1  any non-OKAY resp or burst-length violation
- m_awvalid_o / m_awready_i / m_awaddr_o[ADDR_W] / m_awlen_o[8]  AXI AW
- m_wvalid_o / m_wready_i / m_wdata_o[512] / m_wstrb_o[64] / m_wlast_o  AXI W
- m_bvalid_i / m_bready_o / m_bresp_i[2]  AXI B
- m_arvalid_o / m_arready_i / m_araddr_o[ADDR_W] / m_arlen_o[8]  AXI AR
- m_rvalid_i / m_rready_o / m_rdata_i[512] / m_rresp_i[2] / m_rlast_i  AXI R

Behaviour:
- Reset values: all outputs 0, except req_ready_o = 1. FSM returns to IDLE; beat counter and error flag clear. An in-flight AXI transaction is abandoned; the interconnect is reset together with the block.
- FSM states: IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R, RSP.
- IDLE:
  - req_ready_o = 1.
  - On a handshake: latch address (low 6 bits zeroed), mode and req_md_i; clear err and beat count.
  - Next state is WR_AW for a write, RD_AR for a read.
  - req_ready_o drops the following cycle.
- WR_AW: awvalid = 1, awaddr = latched address, awlen = NBEATS-1. Hold all until awready, then go to WR_W.
- WR_W:
  - Beat k carries md bits [512k +: 512], zero-padded.
  - wstrb is all ones, except the last beat, where it has LAST_BYTES low ones.
  - BYTESWAP_EN applies the 8-byte swap to wdata and the bit-reverse-per-byte-group to wstrb.
  - wlast = 1 on beat NBEATS-1.
  - Advance on wvalid&wready; after the last beat go to WR_B. wvalid/wdata are stable while stalled.
- WR_B: bready = 1. On bvalid: err |= (bresp != 0), then go to RSP.
- RD_AR: same rules as WR_AW using the AR channel; then go to RD_R.
- RD_R:
  - rready = 1. Each beat is unswapped if BYTESWAP_EN, then stored at [512k +: 512]; bits beyond MD_BITS are dropped.
  - err |= (rresp != 0).
  - Early rlast (k < NBEATS-1): set err and go to RSP.
  - Beat NBEATS-1 without rlast: set err. Keep accepting and discarding beats until rlast, then go to RSP.
- RSP: rsp_valid_o = 1, with rsp_md_o and rsp_err_o stable until rsp_ready_i, then go to IDLE. rsp_valid and req_ready are never both 1.
- Latency with zero AXI stalls:
  - Write: NBEATS+3 cycles from the request handshake to rsp_valid.
  - Read: NBEATS+2 cycles.
- Only one transaction is outstanding at a time.

Test Plan:
- Defaults, write at addr 0xFFF6400013, md size=0x05, way_vld=3'b001, pg_vld=5'b00011 -> one AW, awaddr 0xFFF6400000, awlen 0. One W beat with wlast=1, wstrb 64'h00C0_FFFF_FFFF_FFFF, byte-swapped data. bresp=0 -> rsp_err 0.
- NUM_PAGES=12 (MD_BITS 743, NBEATS 2, LAST_BYTES 29), BYTESWAP_EN=0, write -> awlen 1, beat0 wstrb all ones, beat1 wstrb 64'h0000_0000_1FFF_FFFF with wlast. Hold wready low 3 cycles -> wdata stable.
- Defaults, read; return one beat with the byteswapped image of a known record, rresp 0, rlast 1 -> rsp_md equals the original record, rsp_err 0.
- NUM_PAGES=12, read; beat0 rresp=2'b10, beat1 OK with rlast -> rsp_err 1, beat1 data still stored.
- Read with rlast on beat0 when NBEATS=2 -> RSP after 1 beat, rsp_err 1. Separately, 3 beats with rlast on beat2 -> all 3 accepted, rsp_err 1.
- Assert rst_i during WR_W and hold rsp_ready_i low in RSP for 5 cycles -> reset: all AXI valids 0 next cycle and req_ready 1. Backpressure: rsp_valid/rsp_md held until ready, and no new request accepted meanwhile.
